freq_gate_ctrl: RTL and testbench
=================================

Name: freq_gate_ctrl

Overview:
- Timing/control stage that sits directly upstream and downstream of the 6-digit BCD event counter in the frequency-meter datapath.
- Drives the counter's ENA (measurement gate) and CLR (clear) from the system reference clock.
- After each gate closes and the count settles, samples the counter's 24-bit BCD result into a held display register, with a one-cycle valid strobe.
- Runs measurements back-to-back while RUN is high.

Parameters:
- GATE_CYCLES, 1000, CLK cycles ENA is held high per measurement (≥1).
- CLR_CYCLES, 2, CLK cycles CLR is held high before each gate (≥1).
- SETTLE_CYCLES, 2, CLK cycles between gate close and result capture (≥1).

Ports:
- CLK  input  1  reference clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RUN  input  1  level; 1 = perform measurements continuously.
- Q_IN  input  24  BCD count from the counter, digit 5 in [23:20] … digit 0 in [3:0].
- ENA  output  1  gate to counter, active-high.
- CLR  output  1  clear to counter, active-high.
- LOAD  output  1  one-cycle capture strobe (debug/observability).
- DOUT  output  24  last captured BCD result, held between captures.
- DVALID  output  1  one-cycle pulse; DOUT has just been updated.
- BADBCD  output  1  1 if the last captured value had any digit > 9.
- BUSY  output  1  1 in any state other than IDLE.

Behaviour:
- All outputs registered.
- Reset (RST_N=0, async):
  - State IDLE, ENA=0, CLR=1, LOAD=0, DOUT=0, DVALID=0, BADBCD=0, BUSY=0, cycle counter=0.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE:
  - Outputs: CLR=1, ENA=0.
  - RUN=1 sampled at an edge → CLEAR.
- CLEAR:
  - Outputs: CLR=1, ENA=0.
  - Lasts exactly CLR_CYCLES cycles → GATE.
- GATE:
  - Outputs: CLR=0, ENA=1.
  - Lasts exactly GATE_CYCLES cycles → SETTLE.
- SETTLE:
  - Outputs: CLR=0, ENA=0.
  - Lasts exactly SETTLE_CYCLES cycles → LATCH.
- LATCH:
  - Outputs: CLR=0, ENA=0, LOAD=1, exactly one cycle.
  - On the edge leaving LATCH:
    - DOUT←Q_IN.
    - BADBCD←(any nibble of Q_IN > 9).
    - DVALID=1 for the following single cycle.
  - Next state: CLEAR if RUN=1, else IDLE.
- Cycle counter:
  - Width = clog2 of the largest parameter.
  - Loads 0 on each state entry; state exits when count = N-1.
  - Never wraps inside a state.
- RUN=0 sampled in CLEAR, GATE or SETTLE:
  - Abort to IDLE on that edge.
  - No LOAD, no DVALID; DOUT/BADBCD retain previous values.
- RUN=0 during LATCH: capture still completes, then → IDLE.
- RUN re-asserted in the same cycle the FSM reaches IDLE: next edge → CLEAR; no extra idle cycles beyond one.
- ENA and CLR are never both 1.
  - A CLR=1 cycle separates every gate; at least one ENA=0 cycle follows every gate before LOAD.
- DVALID is never asserted for two consecutive cycles.
- Q_IN is sampled only on the LATCH exit edge; changes at other times have no effect.
- Reset mid-operation: immediate return to reset values; DOUT is cleared.
- Measurement period with RUN held high = CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles.

Test Plan:
- Params 2/8/2 (CLR/GATE/SETTLE), RST_N low then high, RUN=0 → CLR=1, ENA=0, BUSY=0, DOUT=0 indefinitely.
- RUN=1 at cycle 0, Q_IN=24'h000123:
  - CLR=1 for 2 cycles, ENA=1 for exactly 8, ENA=0 for 2, LOAD for 1.
  - Then DOUT=24'h000123, DVALID for 1 cycle, BADBCD=0.
  - Next CLR begins immediately.
- RUN held high, Q_IN changed to 24'h999999 then 24'h000000 across periods:
  - DVALID every 13 cycles.
  - DOUT follows 999999 then 000000.
  - ENA and CLR never simultaneously high.
- Q_IN=24'h0A0000 at LATCH → DOUT=24'h0A0000, BADBCD=1; a later clean capture of 24'h000050 clears BADBCD.
- RUN dropped during GATE cycle 4:
  - Next edge IDLE, CLR=1, no LOAD, no DVALID, DOUT unchanged.
  - RUN re-raised → full CLEAR/GATE sequence from start.
- RST_N pulsed low during SETTLE → immediate ENA=0, CLR=1, DOUT=0, DVALID=0; no capture occurs.

Source files
------------

// File: rtl/freq_gate_ctrl_if.sv
// Bundle between the gate controller, the BCD event counter and the display side.
// master = controller (drives gate/clear and result), slave = counter/display/host.
interface freq_gate_ctrl_if;
   logic        RUN;
   logic [23:0] Q_IN;
   logic        ENA;
   logic        CLR;
   logic        LOAD;
   logic [23:0] DOUT;
   logic        DVALID;
   logic        BADBCD;
   logic        BUSY;

   modport master (
      input  RUN,
      input  Q_IN,
      output ENA,
      output CLR,
      output LOAD,
      output DOUT,
      output DVALID,
      output BADBCD,
      output BUSY
   );

   modport slave (
      output RUN,
      output Q_IN,
      input  ENA,
      input  CLR,
      input  LOAD,
      input  DOUT,
      input  DVALID,
      input  BADBCD,
      input  BUSY
   );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Gate/clear sequencer for the 6-digit BCD event counter: clear, gate, settle,
// then capture the count into a held display register with a one-cycle valid strobe.
module freq_gate_ctrl #(
   parameter int GATE_CYCLES   = 1000,
   parameter int CLR_CYCLES    = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   freq_gate_ctrl_if.master  bus
);

   localparam int DATA_W  = 24;
   localparam int MAX_12  = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
   localparam int MAX_CYC = (MAX_12 > SETTLE_CYCLES) ? MAX_12 : SETTLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_GATE   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_LATCH  = 3'd4;

   localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   function automatic logic bcd_invalid(input logic [DATA_W-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DATA_W / 4; i++) begin
         if (v[4*i +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   logic [2:0]        state_p0;
   logic [2:0]        state_nxt;
   logic [CNT_W-1:0]  cnt_p0;
   logic [CNT_W-1:0]  cnt_nxt;

   logic              ena_p1;
   logic              clr_p1;
   logic              load_p1;
   logic              busy_p1;
   logic              vld_p1;
   logic [DATA_W-1:0] dout_p1;
   logic              bad_p1;

   // RUN low aborts any pre-capture state; once in LATCH the capture always completes.
   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         S_IDLE: begin
            if (bus.RUN) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (!bus.RUN)                state_nxt = S_IDLE;
            else if (cnt_p0 == CLR_LAST) state_nxt = S_GATE;
         end
         S_GATE: begin
            if (!bus.RUN)                 state_nxt = S_IDLE;
            else if (cnt_p0 == GATE_LAST) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (!bus.RUN)                   state_nxt = S_IDLE;
            else if (cnt_p0 == SETTLE_LAST) state_nxt = S_LATCH;
         end
         S_LATCH: begin
            state_nxt = bus.RUN ? S_CLEAR : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt = cnt_p0 + CNT_W'(1);
      if (state_nxt != state_p0 || state_p0 == S_IDLE) cnt_nxt = '0;
   end

   // Control stage: outputs decoded from the next state so they line up with the state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_p0 <= S_IDLE;
         cnt_p0   <= '0;
         ena_p1   <= 1'b0;
         clr_p1   <= 1'b1;
         load_p1  <= 1'b0;
         busy_p1  <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         cnt_p0   <= cnt_nxt;
         ena_p1   <= (state_nxt == S_GATE);
         clr_p1   <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
         load_p1  <= (state_nxt == S_LATCH);
         busy_p1  <= (state_nxt != S_IDLE);
         vld_p1   <= (state_p0 == S_LATCH);
      end
   end

   // Capture stage: result is taken on the edge that leaves LATCH and held until the next one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dout_p1 <= '0;
         bad_p1  <= 1'b0;
      end else if (state_p0 == S_LATCH) begin
         dout_p1 <= bus.Q_IN;
         bad_p1  <= bcd_invalid(bus.Q_IN);
      end
   end

   assign bus.ENA    = ena_p1;
   assign bus.CLR    = clr_p1;
   assign bus.LOAD   = load_p1;
   assign bus.BUSY   = busy_p1;
   assign bus.DVALID = vld_p1;
   assign bus.DOUT   = dout_p1;
   assign bus.BADBCD = bad_p1;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl (CLR/GATE/SETTLE = 2/8/2, period 13) with a capture scoreboard.
module tb_freq_gate_ctrl;

   logic CLK;
   logic RST_N;
   int   cyc;
   int   n_total;
   int   n_bad;

   typedef struct {
      logic [23:0] dout;
      logic        bad;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

   freq_gate_ctrl_if bus ();

   freq_gate_ctrl #(
      .GATE_CYCLES   (8),
      .CLR_CYCLES    (2),
      .SETTLE_CYCLES (2)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, act=timeout req=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: act=%0h req=%0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   function automatic exp_t mk(input logic [23:0] d, input logic b, input int c);
      exp_t x;
      x.dout = d;
      x.bad  = b;
      x.cyc  = c;
      return x;
   endfunction

   // {ENA,CLR,LOAD,BUSY} expected k cycles after RUN was raised in IDLE.
   function automatic logic [3:0] seq_exp(input int k);
      if (k <= 2)  return 4'b0101;
      if (k <= 10) return 4'b1001;
      if (k <= 12) return 4'b0001;
      if (k == 13) return 4'b0011;
      return 4'b0101;
   endfunction

   task automatic check_seq(input int c0);
      for (int k = 1; k <= 14; k++) begin
         goto_cyc(c0 + k);
         chk($sformatf("seq_k%0d", k), 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}),
             32'(seq_exp(k)));
      end
   endtask

   // Scoreboard monitor plus cycle-by-cycle invariants.
   always @(negedge CLK) begin
      n_total++;
      if (bus.ENA && bus.CLR) begin
         n_bad++;
         $display("FAIL ena_clr_overlap: act=11 req=not both (cyc %0d)", cyc);
      end
      if (bus.DVALID) begin
         n_total++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_dvalid: act dout=%h req=no capture (cyc %0d)", bus.DOUT, cyc);
         end else begin
            e_mon = sb.pop_front();
            if (bus.DOUT !== e_mon.dout || bus.BADBCD !== e_mon.bad || cyc != e_mon.cyc) begin
               n_bad++;
               $display("FAIL capture: act dout=%h bad=%b cyc=%0d req dout=%h bad=%b cyc=%0d",
                        bus.DOUT, bus.BADBCD, cyc, e_mon.dout, e_mon.bad, e_mon.cyc);
            end
         end
      end
   end

   initial begin
      int c0;
      int c1;
      int c2;
      n_total = 0;
      n_bad   = 0;
      RST_N    = 1'b0;
      bus.RUN  = 1'b0;
      bus.Q_IN = 24'h0;

      repeat (3) @(negedge CLK);
      chk("reset_ctl", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.DVALID, bus.BADBCD, bus.BUSY}),
          32'(6'b010000));
      chk("reset_dout", 32'(bus.DOUT), 32'h0);
      RST_N = 1'b1;
      repeat (6) @(negedge CLK);
      chk("idle_ctl", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}), 32'(4'b0100));
      chk("idle_dout", 32'(bus.DOUT), 32'h0);

      // First measurement, then back-to-back periods with Q_IN noise between captures.
      c0 = cyc;
      bus.Q_IN = 24'h000123;
      bus.RUN  = 1'b1;
      sb.push_back(mk(24'h000123, 1'b0, c0 + 14));
      check_seq(c0);
      bus.Q_IN = 24'h555555;
      sb.push_back(mk(24'h999999, 1'b0, c0 + 27));
      goto_cyc(c0 + 24);
      bus.Q_IN = 24'h999999;
      goto_cyc(c0 + 28);
      bus.Q_IN = 24'h111111;
      sb.push_back(mk(24'h000000, 1'b0, c0 + 40));
      goto_cyc(c0 + 37);
      bus.Q_IN = 24'h000000;
      goto_cyc(c0 + 41);
      bus.Q_IN = 24'h0A0000;
      sb.push_back(mk(24'h0A0000, 1'b1, c0 + 53));
      goto_cyc(c0 + 54);
      chk("badbcd_set", 32'(bus.BADBCD), 32'h1);
      bus.Q_IN = 24'h000050;
      sb.push_back(mk(24'h000050, 1'b0, c0 + 66));
      goto_cyc(c0 + 67);
      bus.Q_IN = 24'h777777;

      // Abort in gate cycle 4 of the next period.
      goto_cyc(c0 + 72);
      chk("gate_c4", 32'({bus.ENA, bus.CLR, bus.BUSY}), 32'(3'b101));
      bus.RUN = 1'b0;
      goto_cyc(c0 + 73);
      chk("abort_ctl", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}), 32'(4'b0100));
      chk("abort_dout", 32'({bus.BADBCD, bus.DOUT}), 32'({1'b0, 24'h000050}));
      repeat (4) @(negedge CLK);

      // Restart from scratch, then reset during SETTLE.
      c1 = cyc;
      bus.Q_IN = 24'h246810;
      bus.RUN  = 1'b1;
      sb.push_back(mk(24'h246810, 1'b0, c1 + 14));
      check_seq(c1);
      bus.Q_IN = 24'h999999;
      goto_cyc(c1 + 25);
      chk("settle_ctl", 32'({bus.ENA, bus.CLR, bus.BUSY}), 32'(3'b001));
      RST_N = 1'b0;
      #1;
      chk("midrst_ctl", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.DVALID, bus.BADBCD, bus.BUSY}),
          32'(6'b010000));
      chk("midrst_dout", 32'(bus.DOUT), 32'h0);
      bus.RUN = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      chk("postrst_dout", 32'(bus.DOUT), 32'h0);

      // RUN dropped in LATCH: capture completes; re-raise in the IDLE cycle.
      c2 = cyc;
      bus.Q_IN = 24'h000007;
      bus.RUN  = 1'b1;
      sb.push_back(mk(24'h000007, 1'b0, c2 + 14));
      goto_cyc(c2 + 13);
      chk("latch_load", 32'(bus.LOAD), 32'h1);
      bus.RUN = 1'b0;
      goto_cyc(c2 + 14);
      chk("latch_idle", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}), 32'(4'b0100));
      chk("latch_dout", 32'({bus.DVALID, bus.DOUT}), 32'({1'b1, 24'h000007}));
      bus.RUN = 1'b1;
      goto_cyc(c2 + 15);
      chk("rerun_clear", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}), 32'(4'b0101));
      bus.RUN = 1'b0;
      goto_cyc(c2 + 16);
      chk("rerun_abort", 32'({bus.ENA, bus.CLR, bus.LOAD, bus.BUSY}), 32'(4'b0100));
      repeat (3) @(negedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
